// File: rtl/vout_timing_monitor_if.sv
// Video timing tap and status bundle for vout_timing_monitor.
// master: the timing source / status host side; slave: the monitor itself.
interface vout_timing_monitor_if #(
   parameter int HCNT_WIDTH = 17,
   parameter int VCNT_WIDTH = 17,
   parameter int FCNT_WIDTH = 16
);
   logic                  hsync_i;
   logic                  vsync_i;
   logic                  de_i;
   logic                  clr_i;
   logic [HCNT_WIDTH-1:0] htotal_o;
   logic [HCNT_WIDTH-1:0] hsw_o;
   logic [HCNT_WIDTH-1:0] hactive_o;
   logic [VCNT_WIDTH-1:0] vtotal_o;
   logic [VCNT_WIDTH-1:0] vactive_o;
   logic [FCNT_WIDTH-1:0] frame_cnt_o;
   logic                  frame_done_o;
   logic                  locked_o;
   logic                  err_line_o;
   logic                  err_frame_o;

   modport master (
      output hsync_i, vsync_i, de_i, clr_i,
      input  htotal_o, hsw_o, hactive_o, vtotal_o, vactive_o,
      input  frame_cnt_o, frame_done_o, locked_o, err_line_o, err_frame_o
   );

   modport slave (
      input  hsync_i, vsync_i, de_i, clr_i,
      output htotal_o, hsw_o, hactive_o, vtotal_o, vactive_o,
      output frame_cnt_o, frame_done_o, locked_o, err_line_o, err_frame_o
   );
endinterface

// File: rtl/vout_timing_monitor.sv
// Passive video output timing checker: measures line/frame timing from
// hsync/vsync/de, flags line and frame inconsistencies, and reports lock.
module vout_timing_monitor #(
   parameter int HCNT_WIDTH  = 17,
   parameter int VCNT_WIDTH  = 17,
   parameter int FCNT_WIDTH  = 16,
   parameter int LOCK_FRAMES = 3
) (
   input logic                  clk,
   input logic                  rst_n,
   vout_timing_monitor_if.slave mon
);
   typedef logic [HCNT_WIDTH-1:0] hcnt_t;
   typedef logic [VCNT_WIDTH-1:0] vcnt_t;

   typedef struct packed {
      hcnt_t htotal;
      hcnt_t hsw;
      hcnt_t hactive;
      vcnt_t vtotal;
      vcnt_t vactive;
   } sig_t;

   typedef enum logic [1:0] {UNLOCKED, COUNTING, LOCKED} lock_state_t;

   localparam hcnt_t      H_ONE     = hcnt_t'(1);
   localparam vcnt_t      V_ONE     = vcnt_t'(1);
   localparam logic [3:0] LOCK_LAST = 4'(LOCK_FRAMES - 1);

   function automatic hcnt_t h_inc(input hcnt_t v);
      return (&v) ? v : v + H_ONE;
   endfunction

   function automatic vcnt_t v_inc(input vcnt_t v);
      return (&v) ? v : v + V_ONE;
   endfunction

   // Input history and seen flags
   logic hs_d, vs_d, de_d;
   logic hs_seen, vs_seen;

   // Running counters
   hcnt_t h_cnt, hsw_cnt, de_cnt;
   vcnt_t line_cnt, act_cnt;

   // Per-frame line references
   hcnt_t ref_htotal, ref_hactive;
   logic  ref_h_vld, ref_a_vld, frame_line_err;

   // Frame signature and lock tracking
   sig_t        cur_sig, prev_sig;
   lock_state_t state, state_n;
   logic [3:0]  match_cnt, match_cnt_n;
   logic        locked_n, err_frame_set;

   logic hs_rise, hs_fall, vs_rise, de_rise, de_fall;
   logic frame_end, htotal_latch;
   logic htotal_mis, hactive_mis, line_err_now, sig_match;

   assign hs_rise      = mon.hsync_i & ~hs_d;
   assign hs_fall      = ~mon.hsync_i & hs_d;
   assign vs_rise      = mon.vsync_i & ~vs_d;
   assign de_rise      = mon.de_i & ~de_d;
   assign de_fall      = ~mon.de_i & de_d;
   assign frame_end    = vs_rise & vs_seen;
   assign htotal_latch = hs_rise & hs_seen;

   // A latch coinciding with vsync rise belongs to no frame's reference set.
   assign htotal_mis   = htotal_latch & ref_h_vld & ~vs_rise & (h_cnt != ref_htotal);
   assign hactive_mis  = de_fall & ref_a_vld & ~vs_rise & (de_cnt != ref_hactive);
   assign line_err_now = htotal_mis | hactive_mis;

   // Signature of the frame ending now, using results as they will be latched.
   assign cur_sig = {htotal_latch ? h_cnt   : mon.htotal_o,
                     hs_fall      ? hsw_cnt : mon.hsw_o,
                     de_fall      ? de_cnt  : mon.hactive_o,
                     line_cnt,
                     act_cnt};

   assign sig_match = (cur_sig == prev_sig) & ~frame_line_err;

   // Edge history and the horizontal/vertical measurement counters
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (!rst_n) begin
         hs_d     <= 1'b0;
         vs_d     <= 1'b0;
         de_d     <= 1'b0;
         hs_seen  <= 1'b0;
         vs_seen  <= 1'b0;
         h_cnt    <= '0;
         hsw_cnt  <= '0;
         de_cnt   <= '0;
         line_cnt <= '0;
         act_cnt  <= '0;
      end else begin
         hs_d <= mon.hsync_i;
         vs_d <= mon.vsync_i;
         de_d <= mon.de_i;
         if (hs_rise) hs_seen <= 1'b1;
         if (vs_rise) vs_seen <= 1'b1;

         h_cnt <= hs_rise ? H_ONE : h_inc(h_cnt);

         if (hs_rise)          hsw_cnt <= H_ONE;
         else if (mon.hsync_i) hsw_cnt <= h_inc(hsw_cnt);

         if (de_rise)       de_cnt <= H_ONE;
         else if (mon.de_i) de_cnt <= h_inc(de_cnt);

         // A line starting on the vsync edge is the first line of the new frame.
         if (vs_rise)      line_cnt <= hs_rise ? V_ONE : '0;
         else if (hs_rise) line_cnt <= v_inc(line_cnt);

         if (vs_rise)      act_cnt <= de_rise ? V_ONE : '0;
         else if (de_rise) act_cnt <= v_inc(act_cnt);
      end
   end

   // Latch measured results and the previous-frame signature
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mon.htotal_o     <= '0;
         mon.hsw_o        <= '0;
         mon.hactive_o    <= '0;
         mon.vtotal_o     <= '0;
         mon.vactive_o    <= '0;
         mon.frame_done_o <= 1'b0;
         prev_sig         <= '0;
      end else begin
         if (htotal_latch) mon.htotal_o  <= h_cnt;
         if (hs_fall)      mon.hsw_o     <= hsw_cnt;
         if (de_fall)      mon.hactive_o <= de_cnt;
         if (frame_end) begin
            mon.vtotal_o  <= line_cnt;
            mon.vactive_o <= act_cnt;
            prev_sig      <= cur_sig;
         end
         mon.frame_done_o <= frame_end;
      end
   end

   // Per-frame reference capture for line-to-line consistency
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ref_htotal     <= '0;
         ref_hactive    <= '0;
         ref_h_vld      <= 1'b0;
         ref_a_vld      <= 1'b0;
         frame_line_err <= 1'b0;
      end else if (vs_rise) begin
         ref_h_vld      <= 1'b0;
         ref_a_vld      <= 1'b0;
         frame_line_err <= 1'b0;
      end else begin
         if (htotal_latch && !ref_h_vld) begin
            ref_htotal <= h_cnt;
            ref_h_vld  <= 1'b1;
         end
         if (de_fall && !ref_a_vld) begin
            ref_hactive <= de_cnt;
            ref_a_vld   <= 1'b1;
         end
         if (line_err_now) frame_line_err <= 1'b1;
      end
   end

   // Lock state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= UNLOCKED;
         match_cnt    <= '0;
         mon.locked_o <= 1'b0;
      end else begin
         state        <= state_n;
         match_cnt    <= match_cnt_n;
         mon.locked_o <= locked_n;
      end
   end

   // Lock next-state: evaluated only at frame end
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      state_n       = state;
      match_cnt_n   = match_cnt;
      locked_n      = mon.locked_o;
      err_frame_set = 1'b0;
      if (frame_end) begin
         unique case (state)
            UNLOCKED: begin
               state_n     = COUNTING;
               match_cnt_n = '0;
            end
            COUNTING: begin
               if (!sig_match) begin
                  match_cnt_n = '0;
               end else if (match_cnt == LOCK_LAST) begin
                  state_n  = LOCKED;
                  locked_n = 1'b1;
               end else begin
                  match_cnt_n = match_cnt + 4'd1;
               end
            end
            LOCKED: begin
               if (!sig_match) begin
                  state_n       = COUNTING;
                  match_cnt_n   = '0;
                  locked_n      = 1'b0;
                  err_frame_set = 1'b1;
               end
            end
            default: state_n = UNLOCKED;
         endcase
      end
   end

   // Sticky error flags and frame counter; a set beats a coincident clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mon.err_line_o  <= 1'b0;
         mon.err_frame_o <= 1'b0;
         mon.frame_cnt_o <= '0;
      end else begin
         if (line_err_now)   mon.err_line_o <= 1'b1;
         else if (mon.clr_i) mon.err_line_o <= 1'b0;

         if (err_frame_set)  mon.err_frame_o <= 1'b1;
         else if (mon.clr_i) mon.err_frame_o <= 1'b0;

         if (frame_end)      mon.frame_cnt_o <= mon.frame_cnt_o + 1'b1;
         else if (mon.clr_i) mon.frame_cnt_o <= '0;
      end
   end
endmodule

// File: tb/tb_vout_timing_monitor.sv
// Scoreboard bench for vout_timing_monitor: 17-cycle lines, 10-line frames,
// expected frame results queued by the stimulus and popped on frame_done_o.
module tb_vout_timing_monitor;
   localparam int HW = 17;
   localparam int VW = 17;
   localparam int FW = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vout_timing_monitor_if #(.HCNT_WIDTH(HW), .VCNT_WIDTH(VW), .FCNT_WIDTH(FW)) vif ();
   vout_timing_monitor_if #(.HCNT_WIDTH(5),  .VCNT_WIDTH(VW), .FCNT_WIDTH(FW)) sif ();

   vout_timing_monitor #(
      .HCNT_WIDTH(HW), .VCNT_WIDTH(VW), .FCNT_WIDTH(FW), .LOCK_FRAMES(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mon(vif)
   );

   vout_timing_monitor #(
      .HCNT_WIDTH(5), .VCNT_WIDTH(VW), .FCNT_WIDTH(FW), .LOCK_FRAMES(3)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n), .mon(sif)
   );

   typedef struct {
      int htotal; int hsw; int hactive; int vtotal; int vactive;
      int fcnt;   int locked; int err_line; int err_frame;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input int fcnt, input int locked, input int el, input int ef);
      exp_t e;
      e = '{htotal: 17, hsw: 2, hactive: 8, vtotal: 10, vactive: 6,
            fcnt: fcnt, locked: locked, err_line: el, err_frame: ef};
      exp_q.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_htotal"},     int'(vif.htotal_o),     0);
      check({tag, "_hsw"},        int'(vif.hsw_o),        0);
      check({tag, "_hactive"},    int'(vif.hactive_o),    0);
      check({tag, "_vtotal"},     int'(vif.vtotal_o),     0);
      check({tag, "_vactive"},    int'(vif.vactive_o),    0);
      check({tag, "_frame_cnt"},  int'(vif.frame_cnt_o),  0);
      check({tag, "_frame_done"}, int'(vif.frame_done_o), 0);
      check({tag, "_locked"},     int'(vif.locked_o),     0);
      check({tag, "_err_line"},   int'(vif.err_line_o),   0);
      check({tag, "_err_frame"},  int'(vif.err_frame_o),  0);
   endtask

   // One clock of stimulus; returns #1 after the edge that sampled it.
   task automatic drive(input logic hs, input logic vs, input logic de);
      vif.hsync_i = hs;
      vif.vsync_i = vs;
      vif.de_i    = de;
      @(posedge clk);
      #1;
   endtask

   // Unaligned: vsync rises at line 0 cycle 5; aligned: on the line-1 hsync rise.
   function automatic logic vs_at(input bit aligned, input int line, input int c);
      int vl;
      int off;
      vl  = aligned ? 1 : 0;
      off = aligned ? 0 : 5;
      return (line == vl && c >= off) || (line == vl + 1 && c < off);
   endfunction

   // Line layout: hsync c0-1, back porch c2-4, active c5-12, front porch c13+.
   task automatic send_line(input bit aligned, input int line, input int c_from, input int c_to);
      for (int c = c_from; c < c_to; c++)
         drive(c < 2, vs_at(aligned, line, c), (line >= 2 && line <= 7) && c >= 5 && c < 13);
   endtask

   task automatic send_lines(input bit aligned, input int l_from, input int l_to, input int stretch);
      for (int l = l_from; l < l_to; l++)
         send_line(aligned, l, 0, (l == stretch) ? 18 : 17);
   endtask

   task automatic send_frame(input bit aligned);
      send_lines(aligned, 0, 10, -1);
   endtask

   task automatic drive_sat(input logic hs);
      sif.hsync_i = hs;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare each frame_done_o pulse against the next queued frame.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && vif.frame_done_o) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_frame_done: got pulse, expected none (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check("fe_htotal",    int'(vif.htotal_o),    e.htotal);
               check("fe_hsw",       int'(vif.hsw_o),       e.hsw);
               check("fe_hactive",   int'(vif.hactive_o),   e.hactive);
               check("fe_vtotal",    int'(vif.vtotal_o),    e.vtotal);
               check("fe_vactive",   int'(vif.vactive_o),   e.vactive);
               check("fe_frame_cnt", int'(vif.frame_cnt_o), e.fcnt);
               check("fe_locked",    int'(vif.locked_o),    e.locked);
               check("fe_err_line",  int'(vif.err_line_o),  e.err_line);
               check("fe_err_frame", int'(vif.err_frame_o), e.err_frame);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vif.hsync_i = 1'b0; vif.vsync_i = 1'b0; vif.de_i = 1'b0; vif.clr_i = 1'b0;
      sif.hsync_i = 1'b0; sif.vsync_i = 1'b0; sif.de_i = 1'b0; sif.clr_i = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;

      // Frames 1-5: four frame ends, lock on the fourth.
      send_frame(0);
      push_frame(1, 0, 0, 0); send_frame(0);
      push_frame(2, 0, 0, 0); send_frame(0);
      push_frame(3, 0, 0, 0); send_frame(0);
      push_frame(4, 1, 0, 0); send_frame(0);
      check("locked_after_fe4", int'(vif.locked_o), 1);

      // Frame 6 normal; frame 7 has line 4 stretched to 18 cycles.
      push_frame(5, 1, 0, 0); send_frame(0);
      push_frame(6, 1, 0, 0);
      send_lines(0, 0, 5, 4);
      check("err_line_before_latch", int'(vif.err_line_o), 0);
      send_line(0, 5, 0, 1);
      check("err_line_at_latch", int'(vif.err_line_o), 1);
      check("htotal_stretched", int'(vif.htotal_o), 18);
      send_line(0, 5, 1, 17);
      send_lines(0, 6, 10, -1);

      // Lock drops at the end of frame 7, relocks three frame ends later.
      push_frame(7, 0, 1, 1); send_frame(0);
      push_frame(8, 0, 1, 1); send_frame(0);
      push_frame(9, 0, 1, 1); send_frame(0);

      // Frame 11: clear errors and frame count while locked.
      push_frame(10, 1, 1, 1);
      send_lines(0, 0, 3, -1);
      vif.clr_i = 1'b1;
      send_line(0, 3, 0, 1);
      vif.clr_i = 1'b0;
      check("clr_err_line",  int'(vif.err_line_o),  0);
      check("clr_err_frame", int'(vif.err_frame_o), 0);
      check("clr_frame_cnt", int'(vif.frame_cnt_o), 0);
      check("clr_locked",    int'(vif.locked_o),    1);
      send_line(0, 3, 1, 17);
      send_lines(0, 4, 10, -1);

      // Frames 12-13: vsync rise aligned with an hsync rise.
      push_frame(1, 1, 0, 0); send_frame(1);
      push_frame(2, 1, 0, 0); send_frame(1);

      // Frame 14: one frame end, then a one-cycle reset in line 3 front porch.
      push_frame(3, 1, 0, 0);
      send_lines(1, 0, 3, -1);
      send_line(1, 3, 0, 14);
      rst_n = 1'b0;
      send_line(1, 3, 14, 15);
      rst_n = 1'b1;
      check_all_zero("midline_reset");
      send_line(1, 3, 15, 17);
      send_line(1, 4, 0, 1);
      check("htotal_first_rise_after_reset", int'(vif.htotal_o), 0);
      send_line(1, 4, 1, 17);
      send_line(1, 5, 0, 1);
      check("htotal_second_rise_after_reset", int'(vif.htotal_o), 17);
      send_line(1, 5, 1, 17);

      // Narrow-counter instance: period 10, then a saturating 41-cycle period.
      drive_sat(1'b1);
      repeat (9) drive_sat(1'b0);
      drive_sat(1'b1);
      check("sat_htotal_short", int'(sif.htotal_o), 10);
      repeat (40) drive_sat(1'b0);
      drive_sat(1'b1);
      check("sat_htotal_saturated", int'(sif.htotal_o), 31);
      check("sat_hsw", int'(sif.hsw_o), 1);

      repeat (4) @(posedge clk);
      check("pending_frames", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/vout_timing_monitor.md
Name: vout_timing_monitor

Overview:
Passive checker that sits directly downstream of the video output timing stage. It taps hsync/vsync/de and measures the horizontal and vertical timing actually produced. It reports the measured values, detects line-to-line and frame-to-frame inconsistencies, and asserts a lock flag once timing is stable. It is used for bring-up, built-in self-test, and status-register readback.

Parameters:
HCNT_WIDTH, 17, width of horizontal (clock-cycle) counters and results
VCNT_WIDTH, 17, width of vertical (line) counters and results
FCNT_WIDTH, 16, width of frame counter
LOCK_FRAMES, 3, consecutive identical frames required to assert locked_o (1..15)

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous active-low reset
hsync_i  in  1  horizontal sync, active high
vsync_i  in  1  vertical sync, active high
de_i  in  1  data enable
clr_i  in  1  clears sticky error flags and frame_cnt_o
htotal_o  out  HCNT_WIDTH  clock cycles between consecutive hsync rising edges
hsw_o  out  HCNT_WIDTH  cycles hsync high in last completed pulse
hactive_o  out  HCNT_WIDTH  cycles de high in last completed de run
vtotal_o  out  VCNT_WIDTH  hsync rising edges in last complete frame
vactive_o  out  VCNT_WIDTH  de rising edges (active lines) in last complete frame
frame_cnt_o  out  FCNT_WIDTH  completed frames, wraps
frame_done_o  out  1  one-cycle pulse when frame results update
locked_o  out  1  timing stable
err_line_o  out  1  sticky: hactive or htotal differed between lines of one frame
err_frame_o  out  1  sticky: frame result differed from previous frame while locked

Behaviour:
- Reset is synchronous and active low (rst_n), on clock clk. All outputs, counters, previous-sample registers, and valid flags reset to 0.
- Edge detect: each input is registered (x_d, reset 0). Rise = x_i & ~x_d; fall = ~x_i & x_d.
- All outputs are registered. A result is latched on the clock edge where the terminating edge is first sampled, so it is visible one cycle after the input transition.
- Horizontal period counter:
  - On hsync rise: the counter loads 1.
  - On hsync rise, if a prior rise has been seen (hs_seen), htotal_o also latches the counter value.
  - Otherwise the counter increments.
  - The counter saturates at all-ones and never wraps.
- hsw counter: loads 1 on hsync rise, increments while hsync_i=1 (saturating). On fall, hsw_o latches the counter value.
- hactive counter: same rule applied to de_i. On de fall, hactive_o latches the counter value.
- Line consistency:
  - The first htotal and hactive latched after vsync rise are stored as references.
  - Any later latch in the same frame that differs from its reference sets err_line_o.
- Vertical counting:
  - The line counter counts hsync rises since the last vsync rise. When the hsync rise and vsync rise coincide, the line counter loads 1 (that line belongs to the new frame).
  - The active-line counter counts de rises.
  - Both counters saturate.
- Frame end is a vsync rise with vs_seen=1. In the cycle the frame ends:
  - vtotal_o and vactive_o latch their counters.
  - frame_cnt_o increments, wrapping at all-ones.
  - frame_done_o pulses.
  - The first vsync rise after reset only sets vs_seen and produces no pulse.
- Lock state machine:
  - States: UNLOCKED (reset), COUNTING, LOCKED. At each frame end, the signature {htotal, hsw, hactive, vtotal, vactive} is compared with the previous frame's.
  - UNLOCKED → COUNTING on the first frame end; match_cnt=0.
  - COUNTING: on a matching frame, match_cnt increments. When match_cnt reaches LOCK_FRAMES-1 on a match → LOCKED, and locked_o is set in the same edge. On a mismatch, match_cnt=0 and the state stays COUNTING.
  - LOCKED: on a mismatch → COUNTING with match_cnt=0; locked_o clears and err_frame_o is set.
  - If err_line_o is set during the current frame, the frame counts as a mismatch.
- clr_i clears err_line_o, err_frame_o and frame_cnt_o. It does not affect measurements or lock. If clr_i coincides with a set condition, the set wins.
- Reset mid-frame discards all partial counts. The first full measurement occurs only after a complete period is observed.
- de without hsync does not break measurement; hactive is still measured.

Test Plan:
- Bench timing hfp=4, hsw=2, hbp=3, hactive=8 (17-cycle lines), 10 lines/frame with 6 active, 5 frames → htotal_o=17, hsw_o=2, hactive_o=8, vtotal_o=10, vactive_o=6. frame_done_o pulses 4 times. locked_o rises at the 4th frame end (LOCK_FRAMES=3). No errors.
- While locked, stretch one line to 18 cycles → err_line_o=1 at the offending latch. locked_o drops at that frame end, err_frame_o=1, and relock occurs 3 frames later.
- Assert clr_i for one cycle → err flags=0, frame_cnt_o=0, locked_o unchanged.
- Drive rst_n low for one cycle mid-line → all outputs 0. The first htotal_o update occurs only at the second hsync rise after reset.
- Hold hsync_i low for more than 2^HCNT_WIDTH cycles (HCNT_WIDTH=5) → htotal_o = 31 at the next rise, with no wrap.
- Align the vsync rise with an hsync rise → that line counts in the new frame, and vtotal_o is unchanged (10).
